// File: rtl/gpio_poll_ctrl.sv
`default_nettype none
// ============================================================================
// gpio_poll_ctrl : AXI4-Lite master that polls GPIO switches and writes LEDs
// Rev 1.0
// ============================================================================
module gpio_poll_ctrl #(
   parameter int          POLL_CYCLES    = 1000,
   parameter logic [31:0] GPIO_ADDR      = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [1:0]  mode,
   input  logic        clear_err,
   output logic [3:0]  sw_value,
   output logic [3:0]  led_value,
   output logic        busy,
   output logic        timeout_err,
   output logic [31:0] axi_araddr,
   output logic        axi_arvalid,
   input  logic        axi_arready,
   input  logic [31:0] axi_rdata,
   input  logic        axi_rvalid,
   output logic        axi_rready,
   output logic [31:0] axi_awaddr,
   output logic        axi_awvalid,
   input  logic        axi_awready,
   output logic [31:0] axi_wdata,
   output logic        axi_wvalid,
   input  logic        axi_wready,
   output logic        b_ready,
   input  logic        b_valid,
   input  logic [1:0]  b_response
);

   localparam int PW = $clog2(POLL_CYCLES);
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [PW-1:0] C_POLL_LOAD = PW'(POLL_CYCLES - 1);
   localparam logic [TW-1:0] C_TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AR   = 3'd1,
      S_R    = 3'd2,
      S_CALC = 3'd3,
      S_W    = 3'd4,
      S_B    = 3'd5,
      S_WAIT = 3'd6,
      S_ERR  = 3'd7
   } state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [3:0]    r_sw_value;
   logic [3:0]    r_led_value;
   logic [3:0]    r_led_next;
   logic [3:0]    r_prev_sw;
   logic          r_first_poll;
   logic          r_timeout_err;
   logic          r_aw_done;
   logic          r_w_done;
   logic [TW-1:0] r_to_cnt;
   logic [PW-1:0] r_timer;
   logic [3:0]    w_led_calc;
   logic          w_to_hit;
   logic          w_aw_hs;
   logic          w_w_hs;
   logic          w_unused;

   assign w_unused = &{1'b0, axi_rdata[31:4], b_response};

   assign axi_araddr  = GPIO_ADDR;
   assign axi_awaddr  = GPIO_ADDR;
   assign axi_wdata   = {28'd0, r_led_next};
   assign axi_arvalid = (r_state == S_AR);
   assign axi_rready  = (r_state == S_R);
   assign axi_awvalid = (r_state == S_W) && !r_aw_done;
   assign axi_wvalid  = (r_state == S_W) && !r_w_done;
   assign b_ready     = (r_state == S_B);
   assign busy        = (r_state == S_AR) || (r_state == S_R) || (r_state == S_CALC) ||
                        (r_state == S_W)  || (r_state == S_B);
   assign sw_value    = r_sw_value;
   assign led_value   = r_led_value;
   assign timeout_err = r_timeout_err;

   assign w_to_hit = (r_to_cnt == C_TO_LAST);
   assign w_aw_hs  = axi_awvalid & axi_awready;
   assign w_w_hs   = axi_wvalid & axi_wready;

   always_comb begin
      w_led_calc = r_led_value;
      case (mode)
         2'd0:    w_led_calc = r_sw_value;
         2'd1:    w_led_calc = ~r_sw_value;
         2'd2:    if (r_sw_value != r_prev_sw) w_led_calc = r_led_value + 4'd1;
         default: w_led_calc = r_led_value;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (en) w_state_next = S_AR;
         S_AR: begin
            if (axi_arready)   w_state_next = S_R;
            else if (w_to_hit) w_state_next = S_ERR;
         end
         S_R: begin
            if (axi_rvalid)    w_state_next = S_CALC;
            else if (w_to_hit) w_state_next = S_ERR;
         end
         S_CALC: begin
            // The first poll after enable always writes so the LEDs match the model.
            if ((w_led_calc != r_led_value) || r_first_poll) w_state_next = S_W;
            else                                            w_state_next = S_WAIT;
         end
         S_W: begin
            if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_state_next = S_B;
            else if (w_to_hit)                                 w_state_next = S_ERR;
         end
         S_B: begin
            if (b_valid)       w_state_next = S_WAIT;
            else if (w_to_hit) w_state_next = S_ERR;
         end
         S_WAIT: if (r_timer == '0) w_state_next = en ? S_AR : S_IDLE;
         S_ERR:  if (clear_err) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sw_value    <= 4'd0;
         r_led_value   <= 4'd0;
         r_led_next    <= 4'd0;
         r_prev_sw     <= 4'd0;
         r_first_poll  <= 1'b1;
         r_timeout_err <= 1'b0;
         r_aw_done     <= 1'b0;
         r_w_done      <= 1'b0;
         r_to_cnt      <= '0;
         r_timer       <= '0;
      end else begin
         // Handshake states leave before the counter passes C_TO_LAST, so it never wraps.
         if (w_state_next != r_state)
            r_to_cnt <= '0;
         else if ((r_state == S_AR) || (r_state == S_R) || (r_state == S_W) || (r_state == S_B))
            r_to_cnt <= r_to_cnt + 1'b1;

         if ((w_state_next == S_WAIT) && (r_state != S_WAIT))
            r_timer <= C_POLL_LOAD;
         else if ((r_state == S_WAIT) && (r_timer != '0))
            r_timer <= r_timer - 1'b1;

         if ((w_state_next == S_ERR) && (r_state != S_ERR))
            r_timeout_err <= 1'b1;

         case (r_state)
            S_IDLE: if (en) r_first_poll <= 1'b1;
            S_R:    if (axi_rvalid) r_sw_value <= axi_rdata[3:0];
            S_CALC: begin
               r_led_next <= w_led_calc;
               r_prev_sw  <= r_sw_value;
               r_aw_done  <= 1'b0;
               r_w_done   <= 1'b0;
            end
            S_W: begin
               if (w_aw_hs) r_aw_done <= 1'b1;
               if (w_w_hs)  r_w_done  <= 1'b1;
            end
            S_B: begin
               if (b_valid) begin
                  r_led_value  <= r_led_next;
                  r_first_poll <= 1'b0;
               end
            end
            S_ERR:  if (clear_err) r_timeout_err <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gpio_poll_ctrl.sv
`default_nettype none
// ============================================================================
// tb_gpio_poll_ctrl : directed self-checking bench for gpio_poll_ctrl
// Rev 1.0
// ============================================================================
module tb_gpio_poll_ctrl;

   localparam int          P  = 8;
   localparam int          TO = 8;
   localparam logic [31:0] A  = 32'h4000_0010;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [1:0]  mode;
   logic        clear_err;
   logic [3:0]  sw_value;
   logic [3:0]  led_value;
   logic        busy;
   logic        timeout_err;
   logic [31:0] axi_araddr;
   logic        axi_arvalid;
   logic        axi_arready = 1'b0;
   logic [31:0] axi_rdata   = 32'd0;
   logic        axi_rvalid  = 1'b0;
   logic        axi_rready;
   logic [31:0] axi_awaddr;
   logic        axi_awvalid;
   logic        axi_awready = 1'b0;
   logic [31:0] axi_wdata;
   logic        axi_wvalid;
   logic        axi_wready  = 1'b0;
   logic        b_ready;
   logic        b_valid     = 1'b0;
   logic [1:0]  b_response  = 2'b10;

   gpio_poll_ctrl #(
      .POLL_CYCLES(P),
      .GPIO_ADDR(A),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .clear_err(clear_err),
      .sw_value(sw_value), .led_value(led_value), .busy(busy), .timeout_err(timeout_err),
      .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
      .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
      .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_wdata(axi_wdata), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
      .b_ready(b_ready), .b_valid(b_valid), .b_response(b_response)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          ar_dly = 1, r_dly = 1, aw_dly = 1, w_dly = 1, b_dly = 1;
   bit          ar_never = 0, aw_never = 0, w_never = 0;
   logic [3:0]  sw_data = 4'h0;
   int          n_ar = 0, n_r = 0, n_aw = 0, n_w = 0, n_b = 0;
   logic [31:0] last_wdata = 32'd0;
   int          cyc = 0, t_wait = 0, t_ar = 0;

   // Slave responder and handshake monitor share one process so ready updates
   // land before the monitor samples the values the next posedge will see.
   initial begin : slave
      int  ar_c, r_c, aw_c, w_c, b_c;
      bit  prev_busy, prev_ar;
      ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0; prev_busy = 0; prev_ar = 0;
      forever begin
         @(negedge clk);
         if (axi_arvalid) begin
            if (!axi_arready) begin ar_c++; if (!ar_never && ar_c > ar_dly) axi_arready = 1'b1; end
         end else begin axi_arready = 1'b0; ar_c = 0; end
         if (axi_rready) begin
            if (!axi_rvalid) begin
               r_c++;
               if (r_c > r_dly) begin axi_rvalid = 1'b1; axi_rdata = {28'hABCDEF0, sw_data}; end
            end
         end else begin axi_rvalid = 1'b0; r_c = 0; end
         if (axi_awvalid) begin
            if (!axi_awready) begin aw_c++; if (!aw_never && aw_c > aw_dly) axi_awready = 1'b1; end
         end else begin axi_awready = 1'b0; aw_c = 0; end
         if (axi_wvalid) begin
            if (!axi_wready) begin w_c++; if (!w_never && w_c > w_dly) axi_wready = 1'b1; end
         end else begin axi_wready = 1'b0; w_c = 0; end
         if (b_ready) begin
            if (!b_valid) begin b_c++; if (b_c > b_dly) b_valid = 1'b1; end
         end else begin b_valid = 1'b0; b_c = 0; end

         if (axi_arvalid && axi_arready) n_ar++;
         if (axi_rvalid && axi_rready)   n_r++;
         if (axi_awvalid && axi_awready) n_aw++;
         if (axi_wvalid && axi_wready) begin n_w++; last_wdata = axi_wdata; end
         if (b_valid && b_ready)         n_b++;
         if (prev_busy && !busy)         t_wait = cyc;
         if (!prev_ar && axi_arvalid)    t_ar = cyc;
         prev_busy = busy;
         prev_ar   = axi_arvalid;
         cyc++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_poll();
      for (int i = 0; i < 200; i++) begin if (busy) break; tick(); end
      check("poll_start", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 200; i++) begin if (!busy) break; tick(); end
      check("poll_end", {31'd0, busy}, 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b0; en = 1'b0; mode = 2'd0; clear_err = 1'b0;
      ar_dly = 1; r_dly = 1; aw_dly = 1; w_dly = 1; b_dly = 1;
      ar_never = 0; aw_never = 0; w_never = 0;
      repeat (3) tick();
      n_ar = 0; n_r = 0; n_aw = 0; n_w = 0; n_b = 0; last_wdata = 32'd0;
      rst = 1'b1;
      tick();
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int tw, cnt;
      bit seen, any_ar;
      logic [3:0] seq_sw  [5];
      logic [3:0] seq_led [5];
      seq_sw  = '{4'h1, 4'h1, 4'h3, 4'h3, 4'h0};
      seq_led = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h3};

      // Reset state
      rst = 1'b0; en = 1'b0; mode = 2'd0; clear_err = 1'b0;
      tick();
      check("rst_outs", {25'd0, busy, timeout_err, axi_arvalid, axi_rready,
                         axi_awvalid, axi_wvalid, b_ready}, 32'd0);
      check("rst_led", {28'd0, led_value}, 32'd0);
      check("rst_sw",  {28'd0, sw_value},  32'd0);

      // Mode 0 mirror, sw=5, then skip on unchanged value and poll spacing
      do_reset();
      sw_data = 4'h5; en = 1'b1;
      wait_poll();
      tw = t_wait;
      check("m0_n_ar", n_ar, 1);
      check("m0_n_aw", n_aw, 1);
      check("m0_n_w",  n_w,  1);
      check("m0_n_b",  n_b,  1);
      check("m0_wdata", last_wdata, 32'h5);
      check("m0_led", {28'd0, led_value}, 32'h5);
      check("m0_sw",  {28'd0, sw_value},  32'h5);
      check("araddr", axi_araddr, A);
      check("awaddr", axi_awaddr, A);
      wait_poll();
      check("m0_poll_gap", t_ar - tw, P);
      check("m0_skip_n_w", n_w, 1);
      check("m0_n_ar2", n_ar, 2);

      // Mode 1 invert, sw=A twice
      do_reset();
      mode = 2'd1; sw_data = 4'hA; en = 1'b1;
      wait_poll();
      check("m1_wdata", last_wdata, 32'h5);
      check("m1_led", {28'd0, led_value}, 32'h5);
      wait_poll();
      check("m1_skip_n_aw", n_aw, 1);
      check("m1_skip_n_w",  n_w,  1);
      check("m1_led2", {28'd0, led_value}, 32'h5);

      // Mode 2 change counter, then wrap from F
      do_reset();
      mode = 2'd2; en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         sw_data = seq_sw[k];
         wait_poll();
         check($sformatf("m2_led_%0d", k), {28'd0, led_value}, {28'd0, seq_led[k]});
      end
      check("m2_n_w", n_w, 3);
      mode = 2'd0; sw_data = 4'hF;
      wait_poll();
      check("m2_preset_F", {28'd0, led_value}, 32'hF);
      mode = 2'd2; sw_data = 4'h0;
      wait_poll();
      check("m2_wrap", {28'd0, led_value}, 32'h0);
      check("m2_wrap_wdata", last_wdata, 32'h0);

      // Split AW/W handshakes
      do_reset();
      aw_dly = 0; w_dly = 3; sw_data = 4'h9; en = 1'b1;
      for (int i = 0; i < 100; i++) begin if (axi_awvalid && axi_awready) break; tick(); end
      check("split_aw_ready", {31'd0, axi_awvalid && axi_awready}, 32'd1);
      tick();
      check("split_aw_drop", {31'd0, axi_awvalid}, 32'd0);
      check("split_w_hold",  {31'd0, axi_wvalid},  32'd1);
      for (int i = 0; i < 200; i++) begin if (!busy) break; tick(); end
      check("split_n_aw", n_aw, 1);
      check("split_n_w",  n_w,  1);
      check("split_n_b",  n_b,  1);
      check("split_led", {28'd0, led_value}, 32'h9);

      // AR timeout, ERR, clear and resume
      do_reset();
      ar_never = 1; sw_data = 4'h5; en = 1'b1;
      cnt = 0; seen = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (axi_arvalid) begin cnt++; seen = 1; end
         else if (seen) break;
      end
      check("to_ar_len", cnt, TO);
      check("to_err", {31'd0, timeout_err}, 32'd1);
      check("to_busy", {31'd0, busy}, 32'd0);
      any_ar = 0;
      for (int i = 0; i < 20; i++) begin tick(); if (axi_arvalid) any_ar = 1; end
      check("to_no_ar", {31'd0, any_ar}, 32'd0);
      check("to_err_sticky", {31'd0, timeout_err}, 32'd1);
      check("to_led", {28'd0, led_value}, 32'h0);
      ar_never = 0; clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      check("to_clear", {31'd0, timeout_err}, 32'd0);
      wait_poll();
      check("to_resume_n_ar", n_ar, 1);
      check("to_resume_led", {28'd0, led_value}, 32'h5);

      // Async reset while stuck in W
      do_reset();
      sw_data = 4'h7; en = 1'b1;
      wait_poll();
      check("ar_pre_led", {28'd0, led_value}, 32'h7);
      aw_never = 1; w_never = 1; sw_data = 4'h3;
      for (int i = 0; i < 100; i++) begin if (axi_awvalid) break; tick(); end
      check("ar_in_w", {31'd0, axi_awvalid}, 32'd1);
      #2 rst = 1'b0;
      #1;
      check("async_outs", {26'd0, busy, axi_arvalid, axi_rready, axi_awvalid,
                           axi_wvalid, b_ready}, 32'd0);
      check("async_led", {28'd0, led_value}, 32'h0);
      check("async_err", {31'd0, timeout_err}, 32'd0);
      check("async_sw",  {28'd0, sw_value},  32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gpio_poll_ctrl.md
Name: gpio_poll_ctrl

Overview:
- AXI4-Lite master that sequences the GPIO slave: periodically reads the switch word, computes a new LED nibble per a mode select, and writes it back.
- Sits between the system control logic and the GPIO AXI-Lite slave.
- Replaces ad-hoc processor polling and owns the slave's AR/R/AW/W/B channels exclusively.

Parameters:
- POLL_CYCLES, 1000, clk cycles from end of one poll to start of the next (min 2).
- GPIO_ADDR, 32'h0000_0000, byte address driven on axi_araddr and axi_awaddr.
- TIMEOUT_CYCLES, 255, max cycles spent waiting in any single handshake state (min 1).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  polling enable.
- mode  in  2  0 = mirror sw to led, 1 = invert, 2 = count sw changes, 3 = hold (no led change).
- clear_err  in  1  clears timeout_err and releases the ERR state.
- sw_value  out  4  last sampled switch nibble.
- led_value  out  4  last LED nibble successfully written (B handshake done).
- busy  out  1  high in any state except IDLE, WAIT and ERR.
- timeout_err  out  1  sticky; set on handshake timeout.
- axi_araddr  out  32  read address (= GPIO_ADDR).
- axi_arvalid  out  1  read address valid.
- axi_arready  in  1  read address ready.
- axi_rdata  in  32  read data; bits [3:0] = switches.
- axi_rvalid  in  1  read data valid.
- axi_rready  out  1  read data ready.
- axi_awaddr  out  32  write address (= GPIO_ADDR).
- axi_awvalid  out  1  write address valid.
- axi_awready  in  1  write address ready.
- axi_wdata  out  32  {28'd0, led_next}.
- axi_wvalid  out  1  write data valid.
- axi_wready  in  1  write data ready.
- b_ready  out  1  write response ready.
- b_valid  in  1  write response valid.
- b_response  in  2  write response; ignored except as noted.

Behaviour:
- Reset (rst=0, async): state IDLE. All valid/ready outputs 0. sw_value, led_value and prev_sw = 0. timeout_err=0, busy=0, first_poll=1, timers=0.
- Handshake rule: a transfer occurs on a posedge where valid & ready are both 1. The master holds valid and payload stable until that edge.
- IDLE: if en=1, set first_poll=1 and go to AR on the next cycle (first poll is immediate).
- AR: axi_arvalid=1. On handshake, clear arvalid and go to R.
- R: axi_rready=1. On rvalid, capture sw_value <= rdata[3:0], drop rready and go to CALC.
- CALC (1 cycle), compute led_next from the old led_value:
  - mode 0: sw_value.
  - mode 1: ~sw_value.
  - mode 2: led_value+1 if sw_value != prev_sw, else led_value. 4-bit wrap, F -> 0.
  - mode 3: led_value.
  - Always update prev_sw <= sw_value.
  - If led_next != led_value or first_poll=1, go to W; else go to WAIT (write skipped).
- W: axi_awvalid=1 and axi_wvalid=1 asserted together. Each drops independently after its own handshake. When both are done (same or different cycles), go to B.
- B: b_ready=1. On b_valid: led_value <= led_next, first_poll <= 0, drop b_ready, go to WAIT. A nonzero b_response is treated as OKAY.
- WAIT: load timer with POLL_CYCLES-1 on entry and decrement each cycle. At 0: go to AR if en=1, else IDLE.
- en=0 mid-transaction: the current transaction completes through B (or R/CALC), then WAIT, then IDLE. No valid is ever withdrawn because of en.
- Timeout: each of AR, R, W and B has its own counter, cleared on state entry. Reaching TIMEOUT_CYCLES without completing causes:
  - all valid/ready outputs 0 next cycle;
  - timeout_err=1;
  - state ERR; led_value unchanged.
- ERR: idle outputs. On clear_err=1, clear timeout_err and go to IDLE. A clear_err pulse outside ERR is ignored.
- busy: combinational from state (AR, R, CALC, W, B).

Test Plan:
- Reset, en=1, mode 0, slave returns rdata=32'h5 with 1-cycle ready delays -> one AR, one W with wdata=32'h5; led_value=5 after B; next AR exactly POLL_CYCLES after WAIT entry.
- mode 1, sw=4'hA on two consecutive polls -> first poll writes wdata=32'h5; second poll performs no AW/W (skip, led unchanged).
- mode 2, sw sequence 1,1,3,3,0 -> led_value sequence 1,1,2,2,3. Preset led_value=F with a changing sw -> wraps to 0.
- Slave asserts awready 3 cycles before wready -> awvalid drops after its handshake while wvalid stays high until wready; exactly one B accepted.
- Slave never asserts arready -> arvalid drops after TIMEOUT_CYCLES, timeout_err=1, state ERR, no further AR; clear_err -> IDLE, then polling resumes with en=1.
- Assert rst low while in W with awvalid=1 -> all outputs 0 immediately (async, no clk edge needed); led_value=0, timeout_err=0.
